// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one registered-output sprite ROM among renderers.
// Returns each ROM word tagged with its requester id after a fixed latency.
module sprite_rom_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 4,
    parameter int ROM_LAT = 1
) (
    input  logic                          vga_clk,
    input  logic                          reset_n,
    input  logic                          frame_sync,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_W-1:0]     addr,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [ADDR_W-1:0]             rom_addr,
    output logic                          rom_rd,
    input  logic [DATA_W-1:0]             rom_q,
    output logic                          rd_valid,
    output logic [$clog2(NUM_REQ)-1:0]    rd_id,
    output logic [DATA_W-1:0]             rd_data
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [IDW:0] NR = (IDW+1)'(NUM_REQ);

    logic [IDW-1:0]                ptr_q, ptr_d;
    logic [ADDR_W-1:0]             rom_addr_q, rom_addr_d;
    logic                          rom_rd_q, rom_rd_d;
    logic [IDW-1:0]                iss_id_q, iss_id_d;
    logic [ROM_LAT-1:0]            vld_q, vld_d;
    logic [ROM_LAT-1:0][IDW-1:0]   id_q, id_d;

    logic                          hit;
    logic                          accept;
    logic [IDW-1:0]                win;
    logic [IDW:0]                  sum;
    logic [IDW:0]                  nxt;
    logic [ADDR_W-1:0]             sel_addr;

    // Search upward from ptr, wrapping modulo NUM_REQ; first requester wins.
    always_comb begin
        hit = 1'b0;
        win = '0;
        sum = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr_q} + (IDW+1)'(i);
            if (sum >= NR) begin
                sum = sum - NR;
            end
            if (!hit && req[sum[IDW-1:0]]) begin
                hit = 1'b1;
                win = sum[IDW-1:0];
            end
        end
        gnt = '0;
        if (hit && reset_n) begin
            gnt[win] = 1'b1;
        end
        accept = |gnt;
    end

    always_comb begin
        sel_addr = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (win == IDW'(j)) begin
                sel_addr = addr[j*ADDR_W +: ADDR_W];
            end
        end
        nxt = {1'b0, win} + (IDW+1)'(1);
        if (nxt == NR) begin
            nxt = '0;
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        rom_addr_d = rom_addr_q;
        rom_rd_d   = accept;
        iss_id_d   = iss_id_q;
        if (frame_sync) begin
            ptr_d = '0;
        end else if (accept) begin
            ptr_d = nxt[IDW-1:0];
        end
        if (accept) begin
            rom_addr_d = sel_addr;
            iss_id_d   = win;
        end
    end

    // Valid/id shift register lines up with rom_q ROM_LAT cycles after issue.
    always_comb begin
        vld_d    = '0;
        id_d     = '0;
        vld_d[0] = rom_rd_q;
        id_d[0]  = iss_id_q;
        for (int s = 1; s < ROM_LAT; s++) begin
            vld_d[s] = vld_q[s-1];
            id_d[s]  = id_q[s-1];
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q      <= '0;
            rom_addr_q <= '0;
            rom_rd_q   <= 1'b0;
            iss_id_q   <= '0;
            vld_q      <= '0;
            id_q       <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rom_addr_q <= rom_addr_d;
            rom_rd_q   <= rom_rd_d;
            iss_id_q   <= iss_id_d;
            vld_q      <= vld_d;
            id_q       <= id_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign rom_rd   = rom_rd_q;
    assign rd_valid = vld_q[ROM_LAT-1];
    assign rd_id    = id_q[ROM_LAT-1];
    assign rd_data  = rom_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Randomized bench for sprite_rom_arbiter against a cycle-history model.
// ROM stand-in returns the low nibble of the address one cycle after issue.
module tb_sprite_rom_arbiter;

    localparam int N     = 3;
    localparam int AW    = 15;
    localparam int DW    = 4;
    localparam int LAT   = 1;
    localparam int DEPTH = 1 + LAT;

    logic              vga_clk = 1'b0;
    logic              reset_n;
    logic              frame_sync;
    logic [N-1:0]      req;
    logic [N*AW-1:0]   addr;
    logic [N-1:0]      gnt;
    logic [AW-1:0]     rom_addr;
    logic              rom_rd;
    logic [DW-1:0]     rom_q = '0;
    logic              rd_valid;
    logic [1:0]        rd_id;
    logic [DW-1:0]     rd_data;

    int checks = 0;
    int errors = 0;

    int            ptr;
    int            cyc;
    bit            av  [0:4095];
    int            aid [0:4095];
    logic [AW-1:0] aad [0:4095];
    logic [AW-1:0] last_addr;

    sprite_rom_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .ROM_LAT (LAT)
    ) dut (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .frame_sync (frame_sync),
        .req        (req),
        .addr       (addr),
        .gnt        (gnt),
        .rom_addr   (rom_addr),
        .rom_rd     (rom_rd),
        .rom_q      (rom_q),
        .rd_valid   (rd_valid),
        .rd_id      (rd_id),
        .rd_data    (rd_data)
    );

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) begin
        if (rom_rd) rom_q <= rom_addr[3:0];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r);
        int k;
        for (int o = 0; o < N; o++) begin
            k = (ptr + o) % N;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    task automatic step(input logic [N-1:0] r, input logic [N*AW-1:0] a,
                        input logic fs, output logic [N-1:0] g_obs);
        int k;
        logic [N-1:0] eg;
        bit ev;
        @(negedge vga_clk);
        req = r;
        addr = a;
        frame_sync = fs;
        #1;
        k = pick(r);
        eg = '0;
        if (k >= 0) eg[k] = 1'b1;
        check("gnt", gnt, eg);
        g_obs = gnt;
        check("rom_rd", rom_rd, (cyc >= 1) ? av[cyc-1] : 1'b0);
        check("rom_addr", rom_addr, last_addr);
        ev = (cyc >= DEPTH) ? av[cyc-DEPTH] : 1'b0;
        check("rd_valid", rd_valid, ev);
        if (ev) begin
            check("rd_id", rd_id, aid[cyc-DEPTH]);
            check("rd_data", rd_data, aad[cyc-DEPTH][3:0]);
        end
        @(posedge vga_clk);
        av[cyc] = (k >= 0);
        aid[cyc] = k;
        if (k >= 0) begin
            aad[cyc] = a[k*AW +: AW];
            last_addr = aad[cyc];
        end
        if (fs) ptr = 0;
        else if (k >= 0) ptr = (k + 1) % N;
        cyc++;
    endtask

    task automatic do_reset(input int ncyc);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_rom_rd", rom_rd, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_id", rd_id, 0);
        for (int c = cyc - DEPTH; c <= cyc; c++) begin
            if (c >= 0) av[c] = 1'b0;
        end
        repeat (ncyc) begin
            @(posedge vga_clk);
            av[cyc] = 1'b0;
            cyc++;
            #1;
            check("rst_hold_valid", rd_valid, 0);
        end
        @(negedge vga_clk);
        req = '0;
        frame_sync = 1'b0;
        reset_n = 1'b1;
        ptr = 0;
        last_addr = '0;
        @(posedge vga_clk);
        av[cyc] = 1'b0;
        cyc++;
    endtask

    initial begin
        logic [N-1:0]    g;
        logic [N-1:0]    one;
        logic [N*AW-1:0] a;
        logic [N-1:0]    r;
        reset_n = 1'b0;
        req = 3'b111;
        addr = '0;
        frame_sync = 1'b0;
        ptr = 0;
        cyc = 0;
        last_addr = '0;
        for (int i = 0; i < 4096; i++) av[i] = 1'b0;

        do_reset(3);

        for (int i = 0; i < 6; i++) begin
            a = {15'h0300 + 15'(i), 15'h0200 + 15'(i), 15'h0100 + 15'(i)};
            step(3'b111, a, 1'b0, g);
            one = '0;
            one[i % N] = 1'b1;
            check("rr_seq", g, one);
        end

        a = {15'h1234, 15'h0000, 15'h0000};
        for (int i = 0; i < 4; i++) begin
            step(3'b100, a, 1'b0, g);
            check("only2_gnt", g, 3'b100);
        end
        step(3'b000, a, 1'b0, g);
        check("only2_rom_addr", rom_addr, 15'h1234);
        check("only2_rd_data", rd_data, 4'h4);

        do_reset(1);
        step(3'b111, '0, 1'b0, g);
        step(3'b111, '0, 1'b1, g);
        check("fs_same_cycle", g, 3'b010);
        step(3'b111, '0, 1'b0, g);
        check("fs_rewind", g, 3'b001);

        for (int i = 0; i < 4; i++) step(3'b000, '0, 1'b0, g);
        step(3'b000, '0, 1'b1, g);
        check("idle_addr_hold", rom_addr, last_addr);

        a = {15'h0abc, 15'h0def, 15'h0123};
        step(3'b011, a, 1'b0, g);
        step(3'b011, a, 1'b0, g);
        do_reset(2);
        step(3'b111, a, 1'b0, g);
        check("post_rst_gnt", g, 3'b001);

        for (int i = 0; i < 400; i++) begin
            r = N'($urandom_range(0, 7));
            a = (N*AW)'({$urandom(), $urandom()});
            step(r, a, ($urandom_range(0, 9) == 0), g);
            if ($urandom_range(0, 59) == 0) do_reset(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
